// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//
// Screen/game sequencer for the 1024x768 @ 65 MHz VGA pipeline. Chooses the
// screen the draw chain shows (menu, ready countdown, play, game over, win)
// and tracks the current level and remaining lives. Time is measured in
// frames, one frame per falling edge of vsync.
//
// Ports:
//   clk          65 MHz pixel clock
//   rst          synchronous, active-high reset
//   vsync        vsync from the vga_if timing bus (falling edge = new frame)
//   start_btn    start key level, already synchronised to clk
//   player_hit   one-cycle pulse: player lost a life
//   level_done   one-cycle pulse: level completed
//   state        MENU=0, READY=1, PLAY=2, GAME_OVER=3, WIN=4
//   start_game   high in every state except MENU (hides draw_menu)
//   level        current level index, 0-based
//   lives        remaining lives
//   round_start  one-cycle pulse on the first cycle of PLAY
// ---------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int START_LIVES  = 3,    // 1..3
    parameter int LEVELS       = 3,    // 1..4
    parameter int READY_FRAMES = 60,   // >= 1
    parameter int END_FRAMES   = 180   // >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       player_hit,
    input  logic       level_done,
    output logic [2:0] state,
    output logic       start_game,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic       round_start
);

    // The frame counter only has to reach the larger of the two hold times
    // minus one, so clog2 of the larger value is enough (at least one bit).
    localparam int MAX_FRAMES = (READY_FRAMES > END_FRAMES) ? READY_FRAMES : END_FRAMES;
    localparam int CNT_LOG    = $clog2(MAX_FRAMES);
    localparam int CNT_W      = (CNT_LOG < 1) ? 1 : CNT_LOG;

    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_FRAMES - 1);
    localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_FRAMES - 1);
    localparam logic [1:0]       LAST_LEVEL = 2'(LEVELS - 1);
    localparam logic [1:0]       FULL_LIVES = 2'(START_LIVES);

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_READY     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } state_t;

    state_t           state_reg;
    logic             start_game_reg;
    logic [1:0]       level_reg;
    logic [1:0]       lives_reg;
    logic             round_start_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             vs_d;
    logic             btn_d;

    logic tick;
    logic press;

    // One tick per frame on the vsync falling edge; the start key acts
    // only on its rising edge so a held button cannot retrigger.
    assign tick  = vs_d & ~vsync;
    assign press = start_btn & ~btn_d;

    // Single sequential FSM. Every state change clears the frame counter
    // and sets start_game from the destination state, so start_game moves
    // in the same cycle as state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_MENU;
            start_game_reg  <= 1'b0;
            level_reg       <= 2'd0;
            lives_reg       <= FULL_LIVES;
            round_start_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            vs_d            <= 1'b0;
            btn_d           <= 1'b0;
        end else begin
            vs_d            <= vsync;
            btn_d           <= start_btn;
            round_start_reg <= 1'b0;

            // Default frame counting; any transition below overrides with 0.
            if (tick) begin
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                ST_MENU: begin
                    // Hits, level completions and ticks mean nothing here.
                    if (press) begin
                        state_reg      <= ST_READY;
                        start_game_reg <= 1'b1;
                        level_reg      <= 2'd0;
                        lives_reg      <= FULL_LIVES;
                        frame_cnt_reg  <= '0;
                    end
                end

                ST_READY: begin
                    // Countdown of READY_FRAMES frames before play resumes.
                    if (tick && frame_cnt_reg == READY_LAST) begin
                        state_reg       <= ST_PLAY;
                        start_game_reg  <= 1'b1;
                        round_start_reg <= 1'b1;
                        frame_cnt_reg   <= '0;
                    end
                end

                ST_PLAY: begin
                    // A hit wins over a simultaneous level completion; the
                    // completion is simply lost.
                    if (player_hit) begin
                        frame_cnt_reg  <= '0;
                        start_game_reg <= 1'b1;
                        if (lives_reg <= 2'd1) begin
                            state_reg <= ST_GAME_OVER;
                            lives_reg <= 2'd0;
                        end else begin
                            state_reg <= ST_READY;
                            lives_reg <= lives_reg - 2'd1;
                        end
                    end else if (level_done) begin
                        frame_cnt_reg  <= '0;
                        start_game_reg <= 1'b1;
                        if (level_reg >= LAST_LEVEL) begin
                            state_reg <= ST_WIN;
                        end else begin
                            state_reg <= ST_READY;
                            level_reg <= level_reg + 2'd1;
                        end
                    end
                end

                ST_GAME_OVER, ST_WIN: begin
                    // Fixed-length end screen; the start key cannot cut it
                    // short. Level and lives stay visible until next start.
                    if (tick && frame_cnt_reg == END_LAST) begin
                        state_reg      <= ST_MENU;
                        start_game_reg <= 1'b0;
                        frame_cnt_reg  <= '0;
                    end
                end

                default: begin
                    // Encodings 5..7 are never entered; recover to MENU.
                    state_reg      <= ST_MENU;
                    start_game_reg <= 1'b0;
                    frame_cnt_reg  <= '0;
                end
            endcase
        end
    end

    assign state       = state_reg;
    assign start_game  = start_game_reg;
    assign level       = level_reg;
    assign lives       = lives_reg;
    assign round_start = round_start_reg;

endmodule

// File: tb/tb_game_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctrl
//
// Drives game_state_ctrl with short synthetic vsync frames, a directed game
// scenario and then a long randomized run. A behavioural model (screen,
// frames elapsed on that screen, level, lives) predicts every output, which
// is compared each cycle on the falling clock edge. A few literal checks at
// key points pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;

    localparam int P_START_LIVES  = 3;
    localparam int P_LEVELS       = 3;
    localparam int P_READY_FRAMES = 2;
    localparam int P_END_FRAMES   = 3;

    localparam int S_MENU  = 0;
    localparam int S_READY = 1;
    localparam int S_PLAY  = 2;
    localparam int S_OVER  = 3;
    localparam int S_WIN   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic       start_btn = 1'b0;
    logic       player_hit = 1'b0;
    logic       level_done = 1'b0;
    logic [2:0] state;
    logic       start_game;
    logic [1:0] level;
    logic [1:0] lives;
    logic       round_start;

    game_state_ctrl #(
        .START_LIVES (P_START_LIVES),
        .LEVELS      (P_LEVELS),
        .READY_FRAMES(P_READY_FRAMES),
        .END_FRAMES  (P_END_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .start_btn  (start_btn),
        .player_hit (player_hit),
        .level_done (level_done),
        .state      (state),
        .start_game (start_game),
        .level      (level),
        .lives      (lives),
        .round_start(round_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: which screen, how many frames have elapsed on it,
    // and the game counters.
    int m_screen = S_MENU;
    int m_frames = 0;
    int m_level  = 0;
    int m_lives  = P_START_LIVES;
    int m_round  = 0;
    int m_vs_prev  = 0;
    int m_btn_prev = 0;
    bit model_valid = 1'b0;

    // Observation counters used by literal checks.
    int rs_cnt     = 0;
    int menu_exits = 0;
    int prev_dut_state = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("state",       int'(state),       m_screen);
        chk("start_game",  int'(start_game),  (m_screen != S_MENU) ? 1 : 0);
        chk("level",       int'(level),       m_level);
        chk("lives",       int'(lives),       m_lives);
        chk("round_start", int'(round_start), m_round);
        if (round_start === 1'b1) rs_cnt++;
        if (prev_dut_state == 0 && state === 3'd1) menu_exits++;
        prev_dut_state = int'(state);
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input int r, input int v, input int b, input int h, input int d);
        int  nxt;
        bit  tick_e, press_e;
        if (r != 0) begin
            m_screen = S_MENU; m_frames = 0; m_level = 0;
            m_lives = P_START_LIVES; m_round = 0;
            m_vs_prev = 0; m_btn_prev = 0;
            return;
        end
        tick_e  = (m_vs_prev == 1) && (v == 0);
        press_e = (b == 1) && (m_btn_prev == 0);
        nxt = m_screen;
        case (m_screen)
            S_MENU: if (press_e) begin
                nxt = S_READY; m_lives = P_START_LIVES; m_level = 0;
            end
            S_READY: if (tick_e && m_frames + 1 == P_READY_FRAMES) nxt = S_PLAY;
            S_PLAY: begin
                if (h != 0) begin
                    if (m_lives == 1) begin nxt = S_OVER; m_lives = 0; end
                    else begin nxt = S_READY; m_lives = m_lives - 1; end
                end else if (d != 0) begin
                    if (m_level == P_LEVELS - 1) nxt = S_WIN;
                    else begin nxt = S_READY; m_level = m_level + 1; end
                end
            end
            default: if (tick_e && m_frames + 1 == P_END_FRAMES) nxt = S_MENU;
        endcase
        m_round = (m_screen == S_READY && nxt == S_PLAY) ? 1 : 0;
        if (nxt != m_screen) begin
            $display("[%0t] screen %0d -> %0d level=%0d lives=%0d", $time, m_screen, nxt, m_level, m_lives);
            m_frames = 0;
        end else if (tick_e) begin
            m_frames++;
        end
        m_screen   = nxt;
        m_vs_prev  = v;
        m_btn_prev = b;
    endtask

    // One clock transaction: check outputs, then apply new inputs.
    task automatic step(input int r, input int v, input int b, input int h, input int d);
        @(negedge clk);
        if (model_valid) compare_all();
        rst        = (r != 0);
        vsync      = (v != 0);
        start_btn  = (b != 0);
        player_hit = (h != 0);
        level_done = (d != 0);
        model_step(r, v, b, h, d);
        model_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // One synthetic frame: vsync high for two cycles then low for two.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic press_key();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(1);
    endtask

    task automatic pulse(input int h, input int d);
        step(0, 0, 0, h, d);
        idle(1);
    endtask

    initial begin
        int vs_r, btn_r;

        // ---- 1: reset, held start key, countdown into PLAY ----
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(1);
        chk("reset_state", int'(state), 0);
        chk("reset_lives", int'(lives), 3);
        menu_exits = 0;
        for (int i = 0; i < 100; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t1_menu_exits", menu_exits, 1);
        chk("t1_state", int'(state), 1);
        chk("t1_start_game", int'(start_game), 1);
        chk("t1_lives", int'(lives), 3);
        rs_cnt = 0;
        frames(2);
        idle(2);
        chk("t1_play", int'(state), 2);
        chk("t1_round_pulses", rs_cnt, 1);
        $display("[%0t] test1 done", $time);

        // ---- 2: lose all lives ----
        pulse(1, 0);
        chk("t2_lives2", int'(lives), 2);
        chk("t2_ready", int'(state), 1);
        rs_cnt = 0;
        frames(2);
        idle(1);
        chk("t2_play_again", int'(state), 2);
        chk("t2_fresh_round", rs_cnt, 1);
        pulse(1, 0);
        frames(2);
        idle(1);
        chk("t2_lives1", int'(lives), 1);
        pulse(1, 0);
        chk("t2_game_over", int'(state), 3);
        chk("t2_lives0", int'(lives), 0);
        $display("[%0t] test2 done", $time);

        // ---- 3: no early exit, timeout to MENU, new game ----
        press_key();
        chk("t3_no_exit", int'(state), 3);
        frames(3);
        chk("t3_menu", int'(state), 0);
        chk("t3_start_game0", int'(start_game), 0);
        chk("t3_lives_kept", int'(lives), 0);
        press_key();
        chk("t3_newgame_lives", int'(lives), 3);
        chk("t3_newgame_level", int'(level), 0);
        $display("[%0t] test3 done", $time);

        // ---- 4: simultaneous hit and level_done ----
        frames(2);
        idle(1);
        pulse(1, 1);
        chk("t4_lives", int'(lives), 2);
        chk("t4_level", int'(level), 0);
        chk("t4_state", int'(state), 1);
        $display("[%0t] test4 done", $time);

        // ---- 5: clear all levels ----
        for (int k = 0; k < 3; k++) begin
            frames(2);
            idle(1);
            pulse(0, 1);
        end
        chk("t5_win", int'(state), 4);
        chk("t5_level", int'(level), 2);
        frames(3);
        chk("t5_menu", int'(state), 0);
        $display("[%0t] test5 done", $time);

        // ---- 6: reset during PLAY with level=1, lives=2 ----
        press_key();
        frames(2); idle(1);
        pulse(1, 0);
        frames(2); idle(1);
        pulse(0, 1);
        frames(2); idle(1);
        chk("t6_pre_level", int'(level), 1);
        chk("t6_pre_lives", int'(lives), 2);
        chk("t6_pre_state", int'(state), 2);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t6_state", int'(state), 0);
        chk("t6_level", int'(level), 0);
        chk("t6_lives", int'(lives), 3);
        chk("t6_start_game", int'(start_game), 0);
        chk("t6_round_start", int'(round_start), 0);
        $display("[%0t] test6 done", $time);

        // ---- randomized run against the model ----
        vs_r = 0;
        btn_r = 0;
        for (int i = 0; i < 6000; i++) begin
            int r, h, d;
            if ($urandom_range(0, 3) == 0) vs_r = 1 - vs_r;
            if ($urandom_range(0, 9) == 0) btn_r = 1 - btn_r;
            r = ($urandom_range(0, 499) == 0) ? 1 : 0;
            h = ($urandom_range(0, 24) == 0) ? 1 : 0;
            d = ($urandom_range(0, 14) == 0) ? 1 : 0;
            step(r, vs_r, btn_r, h, d);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level screen/game sequencer for the 1024x768 @ 65 MHz VGA pipeline.
- Decides which screen the draw chain shows: menu, ready countdown, play, game over or win.
- Drives draw_menu's start_game input and provides level/lives/round-start signals to the gameplay draw and logic blocks.
- Time base is frames, counted from falling edges of the VGA vsync.

Parameters:
- START_LIVES, 3: lives loaded at game start; range 1..3.
- LEVELS, 3: number of levels; range 1..4.
- READY_FRAMES, 60: frames spent in READY before PLAY; must be >= 1.
- END_FRAMES, 180: frames held in GAME_OVER or WIN before returning to MENU; must be >= 1.

Ports:
- clk  in  1  65 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- vsync  in  1  vsync from the vga_if timing bus; a falling edge marks a frame boundary
- start_btn  in  1  start key level, already synchronised to clk
- player_hit  in  1  one-cycle pulse: player lost a life
- level_done  in  1  one-cycle pulse: level completed
- state  out  3  current state: MENU=0, READY=1, PLAY=2, GAME_OVER=3, WIN=4
- start_game  out  1  high in every state except MENU (draw_menu hides the menu)
- level  out  2  current level index, 0-based
- lives  out  2  remaining lives
- round_start  out  1  one-cycle pulse on entry to PLAY

Behaviour:
- All outputs are registered.
- Reset values: state=MENU, start_game=0, level=0, lives=START_LIVES, round_start=0. Internal vs_d=0, btn_d=0, frame_cnt=0.
- Reset taken mid-operation returns everything to these values on the next edge; no events are remembered.
- Frame tick: tick = vs_d & ~vsync, where vs_d is vsync registered once.
- Start press: press = start_btn & ~btn_d (rising edge only). A held button never retriggers.
- Latency: state, level, lives and start_game update on the same edge on which tick, press, player_hit or level_done is seen high. They are visible in the following cycle.
- start_game is a registered decode of the next state, so it changes in the same cycle as state.
- frame_cnt:
  - width is clog2(max(READY_FRAMES, END_FRAMES)), minimum 1 bit;
  - cleared on every state change;
  - increments only on tick.
- MENU:
  - press -> READY; load lives=START_LIVES, level=0.
  - player_hit, level_done and tick are ignored.
- READY:
  - tick with frame_cnt==READY_FRAMES-1 -> PLAY; round_start=1 for exactly the first cycle in PLAY.
  - press, player_hit and level_done are ignored.
- PLAY:
  - player_hit has priority over level_done when both occur in the same cycle; that level_done is dropped.
  - player_hit with lives==1 -> GAME_OVER, lives=0.
  - player_hit with lives>1 -> lives-1, then READY.
  - level_done with level==LEVELS-1 -> WIN; level unchanged.
  - level_done with level<LEVELS-1 -> level+1, then READY.
  - press and tick have no effect.
- GAME_OVER / WIN:
  - tick with frame_cnt==END_FRAMES-1 -> MENU.
  - level and lives keep their values until the next game start.
  - press is ignored: no early exit.
- Encodings 5..7 of state are unreachable. If ever reached, they return to MENU on the next edge.
- Lives never underflow; level never exceeds LEVELS-1.

Test Plan:
Bench parameters: READY_FRAMES=2, END_FRAMES=3, START_LIVES=3, LEVELS=3. vsync is driven with short synthetic frames.
1. Reset, then start_btn held high for 100 cycles -> state 0->1 exactly once, start_game=1, lives=3, level=0. Two vsync falling edges later: state=2 and round_start high for exactly 1 cycle.
2. In PLAY, pulse player_hit -> lives=2, state=1. Two frames later: state=2 with a fresh round_start. Repeat until lives=1, then pulse player_hit -> state=3, lives=0.
3. In GAME_OVER, press start_btn -> no change. Three vsync falling edges later: state=0, start_game=0, lives still 0. A new press loads lives=3, level=0.
4. In PLAY, pulse player_hit and level_done in the same cycle -> lives decrements, level unchanged, state=1.
5. Three level_done pulses, each separated by a READY phase (level 0->1->2, then WIN) -> state=4, level=2. After 3 frames: state=0.
6. Assert rst for one cycle during PLAY with level=1, lives=2 -> next cycle state=0, level=0, lives=3, start_game=0, round_start=0.
